// File: rtl/data_memory_unit_pkg.sv
// Shared encodings for the data memory unit: access sizes and controller states.
package data_memory_unit_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_e;

endpackage

// File: rtl/data_memory_unit_if.sv
// Request/response bus of the data memory unit; master issues accesses, slave serves them.
interface data_memory_unit_if #(
   parameter int unsigned ADDR_WIDTH = 32
) ();

   logic                  req;
   logic                  we;
   logic [1:0]            size;
   logic                  sign_ext;
   logic [ADDR_WIDTH-1:0] addr;
   logic [31:0]           wdata;
   logic                  ready;
   logic [31:0]           rdata;
   logic                  rvalid;
   logic                  err;

   modport master (
      output req, we, size, sign_ext, addr, wdata,
      input  ready, rdata, rvalid, err
   );

   modport slave (
      input  req, we, size, sign_ext, addr, wdata,
      output ready, rdata, rvalid, err
   );

endinterface

// File: rtl/mem_byte_align.sv
// Little-endian lane logic: store merge with byte strobes, load extraction and extension,
// and alignment checking for the addressed size.
module mem_byte_align
   import data_memory_unit_pkg::*;
(
   input  size_e       size_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        sign_ext_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] word_i,
   output logic [31:0] wword_o,
   output logic [31:0] rdata_o,
   output logic        misalign_o
);

   logic [3:0]  strobe;
   logic [31:0] wrep;
   logic [31:0] shifted;

   always_comb begin
      strobe     = 4'b0000;
      wrep       = wdata_i;
      misalign_o = 1'b0;
      case (size_i)
         SZ_BYTE: begin
            strobe = 4'b0001 << addr_lo_i;
            wrep   = {4{wdata_i[7:0]}};
         end
         SZ_HALF: begin
            strobe     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wrep       = {2{wdata_i[15:0]}};
            misalign_o = addr_lo_i[0];
         end
         SZ_WORD: begin
            strobe     = 4'b1111;
            misalign_o = (addr_lo_i != 2'b00);
         end
         SZ_RSVD: ;
         default: ;
      endcase
   end

   // Replicated store data lets every strobed lane take its bits straight across.
   always_comb begin
      wword_o = word_i;
      for (int i = 0; i < 4; i++) begin
         if (strobe[i]) wword_o[8*i +: 8] = wrep[8*i +: 8];
      end
   end

   assign shifted = word_i >> {addr_lo_i, 3'b000};

   always_comb begin
      rdata_o = word_i;
      case (size_i)
         SZ_BYTE: rdata_o = {{24{sign_ext_i & shifted[7]}}, shifted[7:0]};
         SZ_HALF: rdata_o = {{16{sign_ext_i & shifted[15]}}, shifted[15:0]};
         default: rdata_o = word_i;
      endcase
   end

endmodule

// File: rtl/data_memory_unit.sv
// Word-organised data memory with byte/half/word access, zero-fill on reset (INIT sweep),
// one-cycle registered load response and one-cycle error pulse for rejected accesses.
module data_memory_unit
   import data_memory_unit_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DEPTH      = 64
) (
   input logic              clk,
   input logic              reset,
   data_memory_unit_if.slave mem_if
);

   localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [31:0] mem_q [DEPTH];

   state_e            state_q, state_d;
   logic [IdxW-1:0]   init_cnt_q, init_cnt_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;
   logic              err_q, err_d;

   logic [ADDR_WIDTH-3:0] word_idx;
   logic [IdxW-1:0]       mem_idx;
   logic [31:0]           cur_word;
   logic [31:0]           merged_word;
   logic [31:0]           load_word;
   logic                  misalign;
   logic                  out_of_range;
   logic                  bad_access;
   logic                  accept;
   size_e                 size;

   logic                  mem_we;
   logic [IdxW-1:0]       mem_waddr;
   logic [31:0]           mem_wdata;

   assign size         = size_e'(mem_if.size);
   assign word_idx     = mem_if.addr[ADDR_WIDTH-1:2];
   assign mem_idx      = mem_if.addr[IdxW+1:2];
   assign cur_word     = mem_q[mem_idx];
   assign out_of_range = (word_idx >= (ADDR_WIDTH-2)'(DEPTH));
   assign bad_access   = (size == SZ_RSVD) | misalign | out_of_range;
   assign accept       = mem_if.req & (state_q == ST_IDLE);

   mem_byte_align u_align (
      .size_i     (size),
      .addr_lo_i  (mem_if.addr[1:0]),
      .sign_ext_i (mem_if.sign_ext),
      .wdata_i    (mem_if.wdata),
      .word_i     (cur_word),
      .wword_o    (merged_word),
      .rdata_o    (load_word),
      .misalign_o (misalign)
   );

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      rdata_d    = rdata_q;
      rvalid_d   = 1'b0;
      err_d      = 1'b0;
      mem_we     = 1'b0;
      mem_waddr  = mem_idx;
      mem_wdata  = merged_word;
      unique case (state_q)
         ST_INIT: begin
            mem_we    = 1'b1;
            mem_waddr = init_cnt_q;
            mem_wdata = 32'h0;
            if (init_cnt_q == IdxW'(DEPTH - 1)) begin
               state_d    = ST_IDLE;
               init_cnt_d = '0;
            end else begin
               init_cnt_d = init_cnt_q + 1'b1;
            end
         end
         ST_IDLE: begin
            if (accept) begin
               if (bad_access) begin
                  err_d = 1'b1;
               end else if (mem_if.we) begin
                  mem_we = 1'b1;
               end else begin
                  rvalid_d = 1'b1;
                  rdata_d  = load_word;
               end
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
         rdata_q    <= 32'h0;
         rvalid_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
         err_q      <= err_d;
      end
   end

   // Array has no reset; contents are defined only by the INIT sweep.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

   assign mem_if.ready  = (state_q == ST_IDLE);
   assign mem_if.rdata  = rdata_q;
   assign mem_if.rvalid = rvalid_q;
   assign mem_if.err    = err_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit: INIT timing, lane stores/loads, rejections, resets.
module tb_data_memory_unit;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sext;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_rvalid;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   localparam int NVEC = 26;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   n;
   vec_t vecs [NVEC];

   data_memory_unit_if #(.ADDR_WIDTH(32)) bus ();

   data_memory_unit #(
      .ADDR_WIDTH (32),
      .DEPTH      (64)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .mem_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic wait_ready(output int cnt);
      cnt = 0;
      while (bus.ready !== 1'b1 && cnt < 200) begin
         step();
         cnt++;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"},  {31'h0, bus.ready},  32'h0);
      chk({tag, "_rvalid"}, {31'h0, bus.rvalid}, 32'h0);
      chk({tag, "_err"},    {31'h0, bus.err},    32'h0);
      chk({tag, "_rdata"},  bus.rdata,           32'h0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      //           we    size   sx    addr          wdata          rv    er    rdata
      vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1122_3344, 1'b0, 1'b0, 32'h0000_0000};
      vecs[1]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0012, 32'hFFFF_FFA5, 1'b0, 1'b0, 32'h0000_0000};
      vecs[2]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         1'b1, 1'b0, 32'h11A5_3344};
      vecs[3]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0012, 32'h0,         1'b1, 1'b0, 32'hFFFF_FFA5};
      vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0012, 32'h0,         1'b1, 1'b0, 32'h0000_00A5};
      vecs[5]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h5555_8001, 1'b0, 1'b0, 32'h0000_00A5};
      vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0,         1'b1, 1'b0, 32'hFFFF_8001};
      vecs[7]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0020, 32'h0,         1'b1, 1'b0, 32'h0000_0000};
      vecs[8]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0021, 32'h0,         1'b0, 1'b1, 32'h0000_0000};
      vecs[9]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0006, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0000};
      vecs[10] = '{1'b1, 2'b11, 1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0000};
      vecs[11] = '{1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h0000_0000};
      vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0,         1'b1, 1'b0, 32'h0000_0000};
      vecs[13] = '{1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,         1'b1, 1'b0, 32'h0000_0000};
      vecs[14] = '{1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,         1'b0, 1'b1, 32'h0000_0000};
      vecs[15] = '{1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_0000};
      vecs[16] = '{1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF};
      vecs[17] = '{1'b0, 2'b00, 1'b0, 32'h0000_000B, 32'h0,         1'b1, 1'b0, 32'h0000_00DE};
      vecs[18] = '{1'b0, 2'b00, 1'b1, 32'h0000_0008, 32'h0,         1'b1, 1'b0, 32'hFFFF_FFEF};
      vecs[19] = '{1'b0, 2'b01, 1'b1, 32'h0000_000A, 32'h0,         1'b1, 1'b0, 32'hFFFF_DEAD};
      vecs[20] = '{1'b0, 2'b01, 1'b0, 32'h0000_000A, 32'h0,         1'b1, 1'b0, 32'h0000_DEAD};
      vecs[21] = '{1'b1, 2'b00, 1'b0, 32'h0000_0023, 32'h0000_007F, 1'b0, 1'b0, 32'h0000_DEAD};
      vecs[22] = '{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         1'b1, 1'b0, 32'h7F01_0000};
      vecs[23] = '{1'b0, 2'b00, 1'b1, 32'h0000_0023, 32'h0,         1'b1, 1'b0, 32'h0000_007F};
      vecs[24] = '{1'b0, 2'b10, 1'b1, 32'h0000_0010, 32'h0,         1'b1, 1'b0, 32'h11A5_3344};
      vecs[25] = '{1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'h11A5_3344};

      reset        = 1'b0;
      bus.req      = 1'b0;
      bus.we       = 1'b0;
      bus.size     = 2'b10;
      bus.sign_ext = 1'b0;
      bus.addr     = 32'h0;
      bus.wdata    = 32'h0;
      step();
      step();
      chk_all_zero("reset");

      // INIT timing with a load held pending across the whole sweep
      reset    = 1'b1;
      bus.req  = 1'b1;
      bus.addr = 32'h0000_003C;
      wait_ready(n);
      chk("init_ready_cycles", n, 32'd64);
      step();
      chk("init_load_rvalid", {31'h0, bus.rvalid}, 32'h1);
      chk("init_load_rdata",  bus.rdata,           32'h0);
      chk("init_load_err",    {31'h0, bus.err},    32'h0);

      // Back-to-back table, one request per cycle
      for (int i = 0; i < NVEC; i++) begin
         bus.req      = 1'b1;
         bus.we       = vecs[i].we;
         bus.size     = vecs[i].size;
         bus.sign_ext = vecs[i].sext;
         bus.addr     = vecs[i].addr;
         bus.wdata    = vecs[i].wdata;
         step();
         chk($sformatf("v%0d_rvalid", i), {31'h0, bus.rvalid}, {31'h0, vecs[i].exp_rvalid});
         chk($sformatf("v%0d_err", i),    {31'h0, bus.err},    {31'h0, vecs[i].exp_err});
         chk($sformatf("v%0d_rdata", i),  bus.rdata,           vecs[i].exp_rdata);
      end

      bus.req = 1'b0;
      step();
      chk("err_one_cycle",    {31'h0, bus.err},    32'h0);
      chk("idle_rvalid_low",  {31'h0, bus.rvalid}, 32'h0);
      chk("rdata_held",       bus.rdata,           32'h11A5_3344);

      // Reset in IDLE discards the just-registered load response
      bus.req  = 1'b1;
      bus.we   = 1'b0;
      bus.size = 2'b10;
      bus.addr = 32'h0000_0008;
      step();
      bus.req = 1'b0;
      chk("inflight_rvalid", {31'h0, bus.rvalid}, 32'h1);
      chk("inflight_rdata",  bus.rdata,           32'hDEAD_BEEF);
      #2 reset = 1'b0;
      #1 chk_all_zero("idle_reset");

      // Reset mid-INIT restarts the sweep from word 0
      step();
      reset = 1'b1;
      repeat (30) step();
      chk("midinit_ready_low", {31'h0, bus.ready}, 32'h0);
      reset = 1'b0;
      #1 chk_all_zero("midinit_reset");
      step();
      step();
      reset = 1'b1;
      wait_ready(n);
      chk("reinit_ready_cycles", n, 32'd64);

      // Memory cleared by the new INIT
      bus.req  = 1'b1;
      bus.addr = 32'h0000_0008;
      step();
      bus.addr = 32'h0000_0010;
      chk("cleared_08_rvalid", {31'h0, bus.rvalid}, 32'h1);
      chk("cleared_08_rdata",  bus.rdata,           32'h0);
      step();
      bus.req = 1'b0;
      chk("cleared_10_rvalid", {31'h0, bus.rvalid}, 32'h1);
      chk("cleared_10_rdata",  bus.rdata,           32'h0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
